// File: rtl/cm0_ahb_pkg.sv
// Shared AHB-lite encodings for the cortex-m0 memory slaves: transfer, size and
// response codes plus the SRAM slave state encoding.
package cm0_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_XFER = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

endpackage

// File: rtl/ahb_lite_lane_dec.sv
// Byte-lane strobe and alignment decode for a 32-bit AHB-lite data bus.
// Strobes for misaligned or oversized transfers are don't-care; callers gate on the flags.
module ahb_lite_lane_dec
    import cm0_ahb_pkg::*;
#(
    parameter int BIG_ENDIAN = 0
) (
    input  logic [1:0] i_addr,
    input  logic [2:0] i_size,
    output logic [3:0] o_lanes,
    output logic       o_misalign
);

    logic [3:0] w_le_lanes;

    always_comb begin
        w_le_lanes = 4'b0000;
        o_misalign = 1'b0;
        case (i_size)
            HSIZE_BYTE: w_le_lanes = 4'b0001 << i_addr;
            HSIZE_HALF: begin
                w_le_lanes = 4'b0011 << {i_addr[1], 1'b0};
                o_misalign = i_addr[0];
            end
            HSIZE_WORD: begin
                w_le_lanes = 4'b1111;
                o_misalign = |i_addr;
            end
            default: w_le_lanes = 4'b0000;
        endcase
    end

    // Byte-invariant big-endian: offset 0 lives on the top lane.
    assign o_lanes = (BIG_ENDIAN != 0) ? {w_le_lanes[0], w_le_lanes[1], w_le_lanes[2], w_le_lanes[3]}
                                       : w_le_lanes;

endmodule

// File: rtl/ahb_lite_sram.sv
// AHB-lite on-chip SRAM slave for the cortex-m0 bus: byte/half/word access,
// programmable wait states, two-cycle ERROR response, write-to-read forwarding.
//   state | meaning
//   IDLE  | no data phase, ready
//   WAIT  | OKAY data phase stalled, counting down
//   XFER  | final OKAY data-phase cycle, write commits at its end
//   ERR1  | first ERROR cycle, not ready
//   ERR2  | second ERROR cycle, ready
module ahb_lite_sram
    import cm0_ahb_pkg::*;
#(
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_STATES = 0,
    parameter int BIG_ENDIAN  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int          ADDR_W    = $clog2(MEM_BYTES);
    localparam int          IDX_W     = (ADDR_W > 2) ? ADDR_W - 2 : 1;
    localparam int          WORDS     = (MEM_BYTES >= 4) ? MEM_BYTES / 4 : 1;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_write;
    logic [3:0]       r_lanes;
    logic [31:0]      r_rdata;
    logic [31:0]      r_mem [WORDS];

    logic             w_accept;
    logic             w_take;
    logic             w_err;
    logic             w_misalign;
    logic [3:0]       w_lanes;
    logic [IDX_W-1:0] w_haddr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_wr_en;
    logic             w_rd_load;
    logic             w_fwd;
    logic [31:0]      w_rd_word;

    ahb_lite_lane_dec #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane_dec (
        .i_addr     (HADDR[1:0]),
        .i_size     (HSIZE),
        .o_lanes    (w_lanes),
        .o_misalign (w_misalign)
    );

    assign w_accept    = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
    assign w_take      = w_accept & HREADYOUT;
    assign w_err       = (HSIZE > HSIZE_WORD) | w_misalign | (HADDR >= MEM_LIMIT);
    assign w_haddr_idx = IDX_W'(HADDR >> 2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_XFER, ST_ERR2: begin
                if (w_take) begin
                    if (w_err) begin
                        w_next = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        w_next = ST_XFER;
                    end else begin
                        w_next = ST_WAIT;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: if (r_cnt == 4'd1) w_next = ST_XFER;
            ST_ERR1: w_next = ST_ERR2;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (r_state)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: HREADYOUT = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_lanes <= 4'b0000;
        end else begin
            if (w_take) begin
                r_idx   <= w_haddr_idx;
                r_write <= HWRITE & ~w_err;
                r_lanes <= w_lanes;
            end
            if (w_take & ~w_err) begin
                r_cnt <= WS_LOAD;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign w_wr_en   = (r_state == ST_XFER) & r_write;
    assign w_rd_idx  = (r_state == ST_WAIT) ? r_idx : w_haddr_idx;
    assign w_rd_load = (w_take & ~w_err & ~HWRITE & (WAIT_STATES == 0))
                     | ((r_state == ST_WAIT) & (r_cnt == 4'd1) & ~r_write);
    assign w_fwd     = w_wr_en & (r_idx == w_rd_idx);

    // A zero-wait read right behind a write to the same word sees the lanes landing this edge.
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        if (w_fwd) begin
            for (int l = 0; l < 4; l++) begin
                if (r_lanes[l]) w_rd_word[8*l +: 8] = HWDATA[8*l +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            for (int l = 0; l < 4; l++) begin
                if (r_lanes[l]) r_mem[r_idx][8*l +: 8] <= HWDATA[8*l +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'h0000_0000;
        end else if (w_rd_load) begin
            r_rdata <= w_rd_word;
        end
    end

    assign HRDATA = r_rdata;

endmodule

// File: tb/tb_ahb_lite_sram.sv
// Scoreboard bench for ahb_lite_sram: two instances (zero-wait little-endian and
// three-wait big-endian) share one bus driver, a byte-array model and a monitor.
`timescale 1ns/1ps
module tb_ahb_lite_sram;
    import cm0_ahb_pkg::*;

    localparam int MEM = 4096;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    bit          sel;

    wire [31:0] rdata0, rdata1;
    wire        rdy0, rdy1, resp0, resp1;
    wire [31:0] m_rdata = sel ? rdata1 : rdata0;
    wire        m_rdy   = sel ? rdy1 : rdy0;
    wire        m_resp  = sel ? resp1 : resp0;

    int checks = 0;
    int failures = 0;

    exp_t        q[$];
    logic [7:0]  mb [2][MEM];
    logic [31:0] last_rd [2];
    bit          dp;
    int          low;
    exp_t        cur;

    always #5 clk = ~clk;

    ahb_lite_sram #(.MEM_BYTES(MEM), .WAIT_STATES(0), .BIG_ENDIAN(0)) u_dut0 (
        .clk(clk), .reset(reset), .HSEL(hsel && !sel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy0),
        .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0));

    ahb_lite_sram #(.MEM_BYTES(MEM), .WAIT_STATES(3), .BIG_ENDIAN(1)) u_dut1 (
        .clk(clk), .reset(reset), .HSEL(hsel && sel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy1),
        .HRDATA(rdata1), .HREADYOUT(rdy1), .HRESP(resp1));

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (dut%0d t=%0t)", name, act, exp, sel, $time);
        end
    endfunction

    // Reference: memory is a plain byte array; lanes map offset o to o or 3-o.
    function automatic void model_accept(logic [31:0] a, bit wr, logic [2:0] sz, logic [31:0] wd);
        exp_t e;
        int   n, off, lane, base;
        e.err   = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) || (a >= 32'(MEM));
        e.rd    = !wr;
        e.waits = e.err ? 1 : (sel ? 3 : 0);
        e.data  = '0;
        if (!e.err) begin
            n    = 1 << sz;
            base = int'(a) & ~3;
            if (wr) begin
                for (int k = 0; k < n; k++) begin
                    off  = (int'(a) + k) % 4;
                    lane = sel ? 3 - off : off;
                    mb[sel][int'(a) + k] = wd[8*lane +: 8];
                end
            end else begin
                for (int l = 0; l < 4; l++) e.data[8*l +: 8] = mb[sel][base + (sel ? 3 - l : l)];
            end
        end
        q.push_back(e);
    endfunction

    task automatic issue(input logic [31:0] a, input bit wr, input logic [2:0] sz, input logic [31:0] wd,
                         input logic [1:0] tr, input bit hs, input bit commit);
        int guard = 0;
        hsel = hs; haddr = a; htrans = tr; hwrite = wr; hsize = sz;
        @(negedge clk);
        while (!m_rdy && guard < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            guard++;
        end
        if (!m_rdy) check("issue_timeout", 32'(m_rdy), 32'd1);
        if (m_rdy && hs && tr[1] && commit) model_accept(a, wr, sz, wd);
        @(posedge clk); #1;
        if (hs && tr[1]) hwdata = wr ? wd : $urandom;
        hsel = 1'b0; htrans = HTRANS_IDLE;
    endtask

    task automatic idle_cycles(input int n);
        hsel = 1'b0; htrans = HTRANS_IDLE;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            dp = 1'b0; low = 0; last_rd[0] = '0; last_rd[1] = '0;
            q.delete();
        end else begin
            if (dp) begin
                if (!m_rdy) begin
                    low++;
                    if (q.size() > 0) check("wait_resp", 32'(m_resp), 32'(q[0].err));
                    if (low > 20) begin
                        check("stuck_not_ready", 32'(m_rdy), 32'd1);
                        low = 0; dp = 1'b0;
                    end
                end else begin
                    if (q.size() == 0) begin
                        check("unexpected_completion", 32'(q.size()), 32'd1);
                    end else begin
                        cur = q.pop_front();
                        check("resp", 32'(m_resp), 32'(cur.err));
                        check("wait_cycles", 32'(low), 32'(cur.waits));
                        if (cur.rd && !cur.err) begin
                            check("rdata", m_rdata, cur.data);
                            last_rd[sel] = cur.data;
                        end else begin
                            check("rdata_hold", m_rdata, last_rd[sel]);
                        end
                    end
                    low = 0;
                end
            end else begin
                check("idle_ready", 32'(m_rdy), 32'd1);
                check("idle_resp", 32'(m_resp), 32'd0);
                check("idle_rdata_hold", m_rdata, last_rd[sel]);
            end
            if (m_rdy) dp = hsel && htrans[1];
        end
    end

    task automatic run_dut(input bit s);
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  tr;
        sel = s;
        for (int w = 0; w < 16; w++) issue(32'(4*w), 1'b1, HSIZE_WORD, $urandom, HTRANS_NONSEQ, 1'b1, 1'b1);
        issue(32'h10, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, HTRANS_NONSEQ, 1'b1, 1'b1);
        issue(32'h10, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1, 1'b1);
        issue(32'h0, 1'b1, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1, 1'b1);
        issue(32'h2, 1'b1, HSIZE_BYTE, s ? 32'h0000_AB00 : 32'h00AB_0000, HTRANS_SEQ, 1'b1, 1'b1);
        issue(32'h0, 1'b1, HSIZE_HALF, s ? 32'h1234_0000 : 32'h0000_1234, HTRANS_NONSEQ, 1'b1, 1'b1);
        issue(32'h0, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1, 1'b1);
        idle_cycles(2);
        issue(32'h2, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1, 1'b1);
        issue(32'(MEM), 1'b1, HSIZE_WORD, 32'hFFFF_FFFF, HTRANS_NONSEQ, 1'b1, 1'b1);
        issue(32'h4, 1'b0, 3'd3, 32'h0, HTRANS_NONSEQ, 1'b1, 1'b1);
        issue(32'h0, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1, 1'b1);
        issue(32'h10, 1'b1, HSIZE_WORD, 32'h1111_1111, HTRANS_IDLE, 1'b1, 1'b1);
        issue(32'h10, 1'b1, HSIZE_WORD, 32'h2222_2222, HTRANS_BUSY, 1'b1, 1'b1);
        issue(32'h10, 1'b1, HSIZE_WORD, 32'h3333_3333, HTRANS_NONSEQ, 1'b0, 1'b1);
        issue(32'h10, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1, 1'b1);
        idle_cycles(2);
        for (int i = 0; i < 150; i++) begin
            sz = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 63));
            if (sz <= 3'd2 && $urandom_range(0, 9) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 14) == 0) a = 32'(MEM) + 32'($urandom_range(0, 255));
            tr = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            issue(a, 1'($urandom_range(0, 1)), sz, $urandom, tr, $urandom_range(0, 19) != 0, 1'b1);
            if ($urandom_range(0, 7) == 0) idle_cycles(1);
        end
        idle_cycles(8);
        check("queue_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        hsize = HSIZE_WORD; hwdata = '0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready0", 32'(rdy0), 32'd1);
        check("rst_resp0", 32'(resp0), 32'd0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_ready1", 32'(rdy1), 32'd1);
        check("rst_resp1", 32'(resp1), 32'd0);
        check("rst_rdata1", rdata1, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_dut(1'b0);
        run_dut(1'b1);

        // Reset lands in the second wait cycle of a write; the write must not commit.
        sel = 1'b1;
        issue(32'h20, 1'b1, HSIZE_WORD, 32'h5555_5555, HTRANS_NONSEQ, 1'b1, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 32'(rdy1), 32'd1);
        check("midrst_resp", 32'(resp1), 32'd0);
        check("midrst_rdata", rdata1, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        issue(32'h20, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1, 1'b1);
        idle_cycles(8);
        check("queue_drained_end", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
